fp_wb_arbiter: RTL and testbench

- Owns the single write port of the FP register file.
- Shares that port between three writeback requesters: FPU result (0), FP load/lwc1 (1) and mtc1 move (2), using round-robin arbitration with a valid/ready handshake.
- Keeps a pending-write scoreboard (one busy bit per FP register) so the decode stage can stall on RAW hazards.
- Sits between the execute/memory stages and the FP register file's fp_reg_write/write_reg/write_data inputs.

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_wb_arbiter_if.sv | 28 ++
 rtl/fp_wb_arbiter_rr_arbiter.sv | 33 +++
 rtl/fp_wb_arbiter.sv | 110 +++++++++++
 tb/tb_fp_wb_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP writeback constants
package fp_pkg;

    localparam int REQ_FPU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MOVE = 2;

    localparam int FP_NUM_REQ  = 3;
    localparam int FP_NUM_REGS = 32;
    localparam int FP_REG_W    = 5;
    localparam int FP_DATA_W   = 32;

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// rtl/fp_wb_arbiter_if.sv - writeback request bus and register-file write port
interface fp_wb_arbiter_if
    import fp_pkg::*;
#(
    parameter int NUM_REQ = FP_NUM_REQ,
    parameter int REG_W   = FP_REG_W,
    parameter int DATA_W  = FP_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*REG_W-1:0]  req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fp_reg_write;
    logic [REG_W-1:0]          write_reg;
    logic [DATA_W-1:0]         write_data;

    modport master (
        output req_valid, req_reg, req_data,
        input  req_ready, fp_reg_write, write_reg, write_data
    );

    modport slave (
        input  req_valid, req_reg, req_data,
        output req_ready, fp_reg_write, write_reg, write_data
    );

endinterface

// File: rtl/fp_wb_arbiter_rr_arbiter.sv
// rtl/fp_wb_arbiter_rr_arbiter.sv - combinational round-robin grant search
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W:0] cand;
    logic           found;

    // rr_ptr < NUM_REQ and k < NUM_REQ, so a single subtraction wraps the sum
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - FP register-file write port arbiter with RAW scoreboard
module fp_wb_arbiter
    import fp_pkg::*;
#(
    parameter int NUM_REQ  = FP_NUM_REQ,
    parameter int NUM_REGS = FP_NUM_REGS,
    parameter int REG_W    = FP_REG_W,
    parameter int DATA_W   = FP_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_wb_arbiter_if.slave      wb,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_reg,
    input  logic [REG_W-1:0]    query_reg1,
    input  logic [REG_W-1:0]    query_reg2,
    output logic                query_busy,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err_double_issue
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                hs;
    logic [REG_W-1:0]    win_reg;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] busy_next;
    logic                double_issue;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid (wb.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are suppressed during reset so no requester believes it was accepted
    assign wb.req_ready = rst_n ? grant : '0;
    assign hs           = |grant;

    always_comb begin
        win_reg  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_reg  = wb.req_reg[i*REG_W +: REG_W];
                win_data = wb.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid)
            set_vec[issue_reg] = 1'b1;
        if (hs)
            clr_vec[win_reg] = 1'b1;
    end

    // Set beats clear: a fresh issue to the register being written becomes its new pending writer
    assign busy_next    = set_vec | (busy_mask & ~clr_vec);
    assign double_issue = issue_valid & busy_mask[issue_reg] & ~clr_vec[issue_reg];
    assign query_busy   = busy_mask[query_reg1] | busy_mask[query_reg2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (hs) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.fp_reg_write <= 1'b0;
            wb.write_reg    <= '0;
            wb.write_data   <= '0;
        end else begin
            wb.fp_reg_write <= hs;
            if (hs) begin
                wb.write_reg  <= win_reg;
                wb.write_data <= win_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask        <= '0;
            err_double_issue <= 1'b0;
        end else begin
            busy_mask <= busy_next;
            if (double_issue)
                err_double_issue <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - directed self-checking bench for fp_wb_arbiter
module tb_fp_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [4:0]  query_reg1;
    logic [4:0]  query_reg2;
    logic        query_busy;
    logic [31:0] busy_mask;
    logic        err_double_issue;

    int n_vec;
    int n_err;

    fp_wb_arbiter_if wb_if ();

    fp_wb_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wb               (wb_if),
        .issue_valid      (issue_valid),
        .issue_reg        (issue_reg),
        .query_reg1       (query_reg1),
        .query_reg2       (query_reg2),
        .query_busy       (query_busy),
        .busy_mask        (busy_mask),
        .err_double_issue (err_double_issue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
        wb_if.req_valid[i]            = v;
        wb_if.req_reg[i*5 +: 5]       = r;
        wb_if.req_data[i*32 +: 32]    = d;
    endtask

    task automatic clear_reqs();
        wb_if.req_valid = '0;
        wb_if.req_reg   = '0;
        wb_if.req_data  = '0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_reg   = '0;
        query_reg1  = '0;
        query_reg2  = '0;
        clear_reqs();
        wb_if.req_valid = 3'b111;
        tick();
        tick();
        check("rst_ready",  {29'd0, wb_if.req_ready}, 32'h0);
        check("rst_we",     {31'd0, wb_if.fp_reg_write}, 32'h0);
        check("rst_busy",   busy_mask, 32'h0);
        check("rst_err",    {31'd0, err_double_issue}, 32'h0);
        clear_reqs();
        rst_n = 1'b1;

        // reset lands between a grant and its write edge
        tick();
        set_req(0, 1'b1, 5'd3, 32'h3F800000);
        issue_valid = 1'b1;
        issue_reg   = 5'd3;
        #1;
        check("midrst_grant", {29'd0, wb_if.req_ready}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready0", {29'd0, wb_if.req_ready}, 32'h0);
        tick();
        check("midrst_we",   {31'd0, wb_if.fp_reg_write}, 32'h0);
        check("midrst_wreg", {27'd0, wb_if.write_reg}, 32'h0);
        check("midrst_wdat", wb_if.write_data, 32'h0);
        check("midrst_busy", busy_mask, 32'h0);
        clear_reqs();
        issue_valid = 1'b0;
        rst_n       = 1'b1;

        // all three requesting: pointer starts at 0 after reset
        tick();
        set_req(0, 1'b1, 5'd10, 32'hA0);
        set_req(1, 1'b1, 5'd11, 32'hA1);
        set_req(2, 1'b1, 5'd12, 32'hA2);
        #1;
        check("rr_g0", {29'd0, wb_if.req_ready}, 32'h1);
        tick();
        check("rr_w0",  {27'd0, wb_if.write_reg}, 32'd10);
        check("rr_d0",  wb_if.write_data, 32'hA0);
        check("rr_g1",  {29'd0, wb_if.req_ready}, 32'h2);
        tick();
        check("rr_w1",  {27'd0, wb_if.write_reg}, 32'd11);
        check("rr_g2",  {29'd0, wb_if.req_ready}, 32'h4);
        tick();
        check("rr_w2",  {27'd0, wb_if.write_reg}, 32'd12);
        check("rr_d2",  wb_if.write_data, 32'hA2);
        check("rr_g3",  {29'd0, wb_if.req_ready}, 32'h1);
        tick();
        check("rr_we3", {31'd0, wb_if.fp_reg_write}, 32'h1);
        check("rr_w3",  {27'd0, wb_if.write_reg}, 32'd10);
        clear_reqs();
        tick();
        check("idle_we",   {31'd0, wb_if.fp_reg_write}, 32'h0);
        check("idle_hold", {27'd0, wb_if.write_reg}, 32'd10);
        check("idle_busy", busy_mask, 32'h0);

        // single load writeback clears its scoreboard bit (rr_ptr now 1)
        issue_valid = 1'b1;
        issue_reg   = 5'd5;
        tick();
        issue_valid = 1'b0;
        check("ld_busy_set", busy_mask, 32'h0000_0020);
        set_req(1, 1'b1, 5'd5, 32'h40490FDB);
        #1;
        check("ld_grant", {29'd0, wb_if.req_ready}, 32'h2);
        tick();
        clear_reqs();
        check("ld_we",   {31'd0, wb_if.fp_reg_write}, 32'h1);
        check("ld_wreg", {27'd0, wb_if.write_reg}, 32'd5);
        check("ld_wdat", wb_if.write_data, 32'h40490FDB);
        check("ld_busy_clr", busy_mask, 32'h0);

        // set and clear on reg 7 in the same cycle (rr_ptr now 2, only FPU valid)
        issue_valid = 1'b1;
        issue_reg   = 5'd7;
        tick();
        set_req(0, 1'b1, 5'd7, 32'h1234);
        #1;
        check("sc_grant", {29'd0, wb_if.req_ready}, 32'h1);
        tick();
        clear_reqs();
        issue_valid = 1'b0;
        check("sc_busy", busy_mask, 32'h0000_0080);
        check("sc_err",  {31'd0, err_double_issue}, 32'h0);
        check("sc_wreg", {27'd0, wb_if.write_reg}, 32'd7);

        // hazard query on reg 2 (rr_ptr now 1)
        issue_valid = 1'b1;
        issue_reg   = 5'd2;
        tick();
        issue_valid = 1'b0;
        query_reg1  = 5'd2;
        query_reg2  = 5'd4;
        #1;
        check("q_2_4", {31'd0, query_busy}, 32'h1);
        query_reg1 = 5'd4;
        query_reg2 = 5'd7;
        #1;
        check("q_4_7", {31'd0, query_busy}, 32'h1);
        query_reg2 = 5'd6;
        #1;
        check("q_4_6", {31'd0, query_busy}, 32'h0);
        query_reg1 = 5'd2;
        query_reg2 = 5'd4;
        set_req(2, 1'b1, 5'd2, 32'hCAFE);
        #1;
        check("q_mv_grant", {29'd0, wb_if.req_ready}, 32'h4);
        check("q_pre_edge", {31'd0, query_busy}, 32'h1);
        tick();
        clear_reqs();
        check("q_post_edge", {31'd0, query_busy}, 32'h0);
        check("q_busy",      busy_mask, 32'h0000_0080);
        check("q_wdat",      wb_if.write_data, 32'hCAFE);

        // double issue to reg 9 is sticky until reset
        issue_valid = 1'b1;
        issue_reg   = 5'd9;
        tick();
        check("dbl_first", {31'd0, err_double_issue}, 32'h0);
        tick();
        issue_valid = 1'b0;
        check("dbl_err", {31'd0, err_double_issue}, 32'h1);
        set_req(0, 1'b1, 5'd9, 32'h99);
        tick();
        clear_reqs();
        check("dbl_busy",   busy_mask, 32'h0000_0080);
        check("dbl_sticky", {31'd0, err_double_issue}, 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        check("dbl_rst_err",  {31'd0, err_double_issue}, 32'h0);
        check("dbl_rst_busy", busy_mask, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
